bin_eq_stim_gen: RTL and testbench

- Sequential stimulus generator that drives the 128-bit packed operand bus consumed by the binary-equality cosim spec (fields a9, a4, a1, b9, b6, b2).
- Emits a fixed table of directed corner vectors, then a run of pseudo-random vectors, over a valid/ready handshake.
- Sits on the producer end of the operand bus in the bin_eq cosim harness and feeds the DUT/reference pair.

---
 rtl/bin_eq_stim_pkg.sv | 101 ++++++++++
 rtl/bin_eq_stim_lfsr32.sv | 52 +++++
 rtl/bin_eq_stim_gen.sv | 159 +++++++++++++++
 tb/tb_bin_eq_stim_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bin_eq_stim_pkg.sv
// bin_eq_stim_pkg
// Shared definitions for the bin_eq operand-bus stimulus generator.
// Contents:
//   - Field widths and offsets of the packed 31-bit operand word.
//   - The FSM state enum.
//   - The 8-entry directed corner table.
//   - The Galois LFSR mask and step function.
//   - The field pack helper.
// Optional feature macro: BIN_EQ_STIM_EQBIAS_EN. When it is defined, this
// package also provides the equal-bias helper.
package bin_eq_stim_pkg;

    localparam int VEC_W  = 31;
    localparam int B2_W   = 2;
    localparam int B2_LSB = 0;
    localparam int B6_W   = 6;
    localparam int B6_LSB = 2;
    localparam int B9_W   = 9;
    localparam int B9_LSB = 8;
    localparam int A1_W   = 1;
    localparam int A1_LSB = 17;
    localparam int A4_W   = 4;
    localparam int A4_LSB = 18;
    localparam int A9_W   = 9;
    localparam int A9_LSB = 22;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIR  = 2'd1,
        RND  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    // Packs the six operand fields into the 31-bit bus word. b2 is placed
    // in the least-significant bits.
    function automatic logic [VEC_W-1:0] pack_fields(
        input logic [A9_W-1:0] a9,
        input logic [A4_W-1:0] a4,
        input logic [A1_W-1:0] a1,
        input logic [B9_W-1:0] b9,
        input logic [B6_W-1:0] b6,
        input logic [B2_W-1:0] b2
    );
        logic [VEC_W-1:0] w;
        w = '0;
        w[A9_LSB +: A9_W] = a9;
        w[A4_LSB +: A4_W] = a4;
        w[A1_LSB +: A1_W] = a1;
        w[B9_LSB +: B9_W] = b9;
        w[B6_LSB +: B6_W] = b6;
        w[B2_LSB +: B2_W] = b2;
        return w;
    endfunction

    // Performs one step of the right-shifting Galois LFSR. The mask is
    // applied only when the bit shifted out is 1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] r;
        r = {1'b0, s[31:1]};
        if (s[0]) begin
            r = r ^ LFSR_MASK;
        end else begin
            r = r;
        end
        return r;
    endfunction

`ifdef BIN_EQ_STIM_EQBIAS_EN
    // Rewrites the b fields from the a fields so that both sides compare
    // equal:
    //   - b9 takes a9.
    //   - b6 takes the sign-extended a4.
    //   - b2 takes a1 replicated into both bits.
    function automatic logic [VEC_W-1:0] eq_bias(input logic [VEC_W-1:0] w);
        logic [VEC_W-1:0] r;
        logic [A4_W-1:0]  a4;
        r  = w;
        a4 = w[A4_LSB +: A4_W];
        r[B9_LSB +: B9_W] = w[A9_LSB +: A9_W];
        r[B6_LSB +: B6_W] = {{(B6_W-A4_W){a4[A4_W-1]}}, a4};
        r[B2_LSB +: B2_W] = {w[A1_LSB], w[A1_LSB]};
        return r;
    endfunction
`endif

    // Directed corner vectors. Each entry lists (a9, a4, a1, b9, b6, b2).
    // Entry 0 sits at the bottom of the packed array.
    localparam logic [7:0][VEC_W-1:0] DIR_TABLE = {
        pack_fields(9'h001, 4'h0, 1'b0, 9'h001, 6'h00, 2'h0),
        pack_fields(9'h100, 4'h0, 1'b0, 9'h000, 6'h00, 2'h0),
        pack_fields(9'h000, 4'h0, 1'b1, 9'h000, 6'h00, 2'h3),
        pack_fields(9'h1FF, 4'h0, 1'b0, 9'h000, 6'h3F, 2'h0),
        pack_fields(9'h000, 4'h8, 1'b0, 9'h000, 6'h38, 2'h0),
        pack_fields(9'h155, 4'hA, 1'b1, 9'h155, 6'h0A, 2'h1),
        pack_fields(9'h1FF, 4'hF, 1'b1, 9'h1FF, 6'h3F, 2'h3),
        pack_fields(9'h000, 4'h0, 1'b0, 9'h000, 6'h00, 2'h0)
    };

endpackage

// File: rtl/bin_eq_stim_lfsr32.sv
// bin_eq_lfsr32
// 32-bit Galois LFSR with a seed load and a step enable.
// Ports:
//   - clk, rst: rising-edge clock and synchronous active-high reset. Reset
//     loads SEED.
//   - load: reload SEED. This takes priority over step.
//   - step: advance the LFSR by one Galois step.
//   - state: current register value.
//   - state_nxt: the value the register takes on the next edge when rst is
//     low. The consumer uses it to register data in the same cycle as the
//     step.
module bin_eq_lfsr32
    import bin_eq_stim_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2345
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    output logic [31:0] state,
    output logic [31:0] state_nxt
);

    logic [31:0] state_r;
    logic [31:0] state_nxt_s;

    // Selects the next LFSR value.
    always_comb begin
        state_nxt_s = state_r;
        if (load) begin
            state_nxt_s = SEED;
        end else if (step) begin
            state_nxt_s = lfsr_step(state_r);
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Holds the LFSR register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= SEED;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    assign state     = state_r;
    assign state_nxt = state_nxt_s;

endmodule

// File: rtl/bin_eq_stim_gen.sv
// bin_eq_stim_gen
// Producer for the bin_eq operand bus. It emits the 8 directed corner
// vectors and then NUM_RANDOM LFSR vectors over a valid/ready handshake.
// Ports:
//   - clk, rst: rising-edge clock and synchronous active-high reset.
//   - start: one-cycle run request. It is honoured only in IDLE or DONE.
//   - vec_valid, vec_ready, vec_data: the handshake and the packed vector.
//     Bits above 30 of vec_data are always 0.
//   - vec_idx: 0-based index of the presented vector.
//   - done: a level that is high once the run has finished.
// Optional feature macro: BIN_EQ_STIM_EQBIAS_EN. When it is defined, random
// vectors with an odd index have their b fields copied from their a fields.
module bin_eq_stim_gen
    import bin_eq_stim_pkg::*;
#(
    parameter int          NUM_RANDOM = 64,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_2345,
    parameter int          OUT_W      = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [OUT_W-1:0] vec_data,
    output logic [15:0]      vec_idx,
    output logic             done
);

    // The index is kept one bit wider so the final-index compare cannot
    // alias for any legal NUM_RANDOM.
    localparam logic [16:0] DIR_LAST_IDX = 17'd7;
    localparam logic [16:0] LAST_IDX     = 17'(8 + NUM_RANDOM - 1);

    state_e           state_r;
    state_e           state_nxt_s;
    logic [16:0]      idx_r;
    logic [16:0]      idx_nxt_s;
    logic             valid_r;
    logic             done_r;
    logic [OUT_W-1:0] data_r;
    logic [OUT_W-1:0] data_nxt_s;
    logic [VEC_W-1:0] word_s;
    logic             xfer_s;
    logic             lfsr_load_s;
    logic             lfsr_step_s;
    logic [31:0]      lfsr_q_s;
    logic [31:0]      lfsr_nxt_s;

    assign xfer_s = valid_r & vec_ready;

    bin_eq_lfsr32 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .load      (lfsr_load_s),
        .step      (lfsr_step_s),
        .state     (lfsr_q_s),
        .state_nxt (lfsr_nxt_s)
    );

    // Computes the next state and index, and the LFSR controls.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        lfsr_load_s = 1'b0;
        lfsr_step_s = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt_s = DIR;
                    idx_nxt_s   = 17'd0;
                    lfsr_load_s = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            DIR: begin
                if (xfer_s) begin
                    idx_nxt_s = idx_r + 17'd1;
                    if (idx_r == DIR_LAST_IDX) begin
                        state_nxt_s = RND;
                    end else begin
                        state_nxt_s = DIR;
                    end
                end else begin
                    state_nxt_s = DIR;
                end
            end
            RND: begin
                if (xfer_s) begin
                    idx_nxt_s   = idx_r + 17'd1;
                    lfsr_step_s = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = RND;
                    end
                end else begin
                    state_nxt_s = RND;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Builds the vector to present next. Because it is derived from the
    // next index and the next LFSR value, a stalled vector recomputes to
    // the same value and stays stable.
    always_comb begin
        word_s     = '0;
        data_nxt_s = '0;
        case (state_nxt_s)
            DIR: begin
                word_s = DIR_TABLE[idx_nxt_s[2:0]];
            end
            RND: begin
                word_s = lfsr_nxt_s[VEC_W-1:0];
`ifdef BIN_EQ_STIM_EQBIAS_EN
                if (idx_nxt_s[0]) begin
                    word_s = eq_bias(word_s);
                end else begin
                    word_s = lfsr_nxt_s[VEC_W-1:0];
                end
`endif
            end
            default: begin
                word_s = '0;
            end
        endcase
        data_nxt_s[VEC_W-1:0] = word_s;
    end

    // Holds the state, the index, and the registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= 17'd0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            data_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            valid_r <= (state_nxt_s == DIR) || (state_nxt_s == RND);
            done_r  <= (state_nxt_s == DONE);
            data_r  <= data_nxt_s;
        end
    end

    assign vec_valid = valid_r;
    assign vec_data  = data_r;
    assign vec_idx   = idx_r[15:0];
    assign done      = done_r;

endmodule

// File: tb/tb_bin_eq_stim_gen.sv
// tb_bin_eq_stim_gen
// Directed self-checking bench for bin_eq_stim_gen.
// Stimulus:
//   - Inputs are driven 1 time unit after each rising edge.
//   - Outputs are sampled at that same point.
// Expected values:
//   - The directed vectors and the first random words are hand-computed
//     constants.
//   - The rest of the random stream comes from a small Galois model in this
//     file.
module tb_bin_eq_stim_gen;

    localparam int          NUM_RANDOM = 64;
    localparam logic [31:0] SEED       = 32'hACE1_2345;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         vec_ready;
    logic         vec_valid;
    logic         done;
    logic [127:0] vec_data;
    logic [15:0]  vec_idx;

    int          vectors_applied = 0;
    int          miscompares     = 0;
    logic [30:0] dir_exp [8];
    logic [30:0] exp_rnd [NUM_RANDOM];

    bin_eq_stim_gen #(
        .NUM_RANDOM (NUM_RANDOM),
        .LFSR_SEED  (SEED),
        .OUT_W      (128)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_data  (vec_data),
        .vec_idx   (vec_idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors_applied++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic valid, input int idx, input logic [30:0] word);
        check_vec({tag, " valid"}, {127'd0, vec_valid}, {127'd0, valid});
        check_vec({tag, " idx"}, {112'd0, vec_idx}, {112'd0, 16'(idx)});
        check_vec({tag, " data"}, vec_data, {97'd0, word});
    endtask

    function automatic logic [31:0] model_step(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    function automatic logic [30:0] model_word(input logic [31:0] s, input int k);
        logic [30:0] w;
        w = s[30:0];
`ifdef BIN_EQ_STIM_EQBIAS_EN
        if ((k % 2) == 1) begin
            w[16:8] = w[30:22];
            w[7:2]  = {{2{w[21]}}, w[21:18]};
            w[1:0]  = {w[17], w[17]};
        end
`else
        if (k < 0) w = 31'd0;
`endif
        return w;
    endfunction

    initial begin
        logic [31:0] l;
        rst       = 1'b1;
        start     = 1'b0;
        vec_ready = 1'b0;
        dir_exp[0] = 31'h0000_0000;
        dir_exp[1] = 31'h7FFF_FFFF;
        dir_exp[2] = 31'h556B_5529;
        dir_exp[3] = 31'h0020_00E0;
        dir_exp[4] = 31'h7FC0_00FC;
        dir_exp[5] = 31'h0002_0003;
        dir_exp[6] = 31'h4000_0000;
        dir_exp[7] = 31'h0040_0100;
        l = SEED;
        for (int k = 0; k < NUM_RANDOM; k++) begin
            exp_rnd[k] = model_word(l, k);
            l = model_step(l);
        end

        tick();
        tick();
        check_out("reset", 1'b0, 0, 31'd0);
        check_vec("reset done", {127'd0, done}, 128'd0);
        rst = 1'b0;
        tick();
        check_out("idle", 1'b0, 0, 31'd0);

        // First run: the directed phase, including a stall at index 4.
        start = 1'b1;
        tick();
        start     = 1'b0;
        vec_ready = 1'b1;
        check_out("dir0", 1'b1, 0, 31'h0000_0000);
        tick();
        check_out("dir1", 1'b1, 1, 31'h7FFF_FFFF);
        tick();
        check_out("dir2", 1'b1, 2, 31'h556B_5529);
        tick();
        check_out("dir3", 1'b1, 3, 31'h0020_00E0);
        tick();
        vec_ready = 1'b0;
        check_out("dir4", 1'b1, 4, 31'h7FC0_00FC);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2) ? 1'b1 : 1'b0;
            tick();
            check_out("stall4", 1'b1, 4, 31'h7FC0_00FC);
        end
        start     = 1'b0;
        vec_ready = 1'b1;
        for (int i = 5; i < 8; i++) begin
            tick();
            check_out("dir", 1'b1, i, dir_exp[i]);
        end

        // Random phase: the first words are hand-computed constants.
        tick();
        check_out("rnd8 seed", 1'b1, 8, 31'h2CE1_2345);
        tick();
`ifdef BIN_EQ_STIM_EQBIAS_EN
        check_out("rnd9 bias", 1'b1, 9, 31'h5651_5910);
`else
        check_out("rnd9 raw", 1'b1, 9, 31'h5650_91A1);
`endif
        tick();
        check_out("rnd10", 1'b1, 10, 31'h6B08_48D3);
        for (int k = 3; k < NUM_RANDOM; k++) begin
            tick();
            check_out("rnd stream", 1'b1, 8 + k, exp_rnd[k]);
            check_vec("done early", {127'd0, done}, 128'd0);
        end
        tick();
        check_vec("done rise", {127'd0, done}, 128'd1);
        check_vec("done valid", {127'd0, vec_valid}, 128'd0);
        check_vec("done data", vec_data, 128'd0);
        tick();
        check_vec("done hold", {127'd0, done}, 128'd1);

        // Restart from DONE, then reset in the middle of the random phase.
        start = 1'b1;
        tick();
        start = 1'b0;
        check_out("restart0", 1'b1, 0, dir_exp[0]);
        check_vec("restart done", {127'd0, done}, 128'd0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check_out("restart dir", 1'b1, i, dir_exp[i]);
        end
        for (int k = 0; k <= 12; k++) begin
            tick();
            check_out("restart rnd", 1'b1, 8 + k, exp_rnd[k]);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_out("midrst", 1'b0, 0, 31'd0);
        check_vec("midrst done", {127'd0, done}, 128'd0);

        // A run after the reset replays the directed table and the same
        // random stream.
        start = 1'b1;
        tick();
        start = 1'b0;
        check_out("replay0", 1'b1, 0, dir_exp[0]);
        for (int i = 1; i < 8; i++) begin
            tick();
            check_out("replay dir", 1'b1, i, dir_exp[i]);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            check_out("replay rnd", 1'b1, 8 + k, exp_rnd[k]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
